// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio -- 8N1 UART receiver with a small memory-mapped read port.
//
// The serial line is synchronized, framed by a four-state FSM and the
// received bytes are held in local storage until the CPU pops them through
// the data address. Status bits (overrun, frame_err, rx_valid) are read at
// the status address; a strobed status read clears the two sticky flags.
//
// Build option: define UART_RX_FIFO_EN for a 4-entry receive FIFO; leave it
// undefined for a single holding register.
//
// Parameters
//   CLK_HZ       system clock frequency in Hz
//   BAUD         line rate; CLKS_PER_BIT = CLK_HZ/BAUD, never below 4
//   DATA_ADDR    address of the receive data register
//   STATUS_ADDR  address of the status register
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rxd        asynchronous serial input, idle high
//   Address    CPU read address
//   rd_en      one-cycle read strobe qualifying Address
//   rd_data    combinational read data (independent of rd_en)
//   rx_valid   at least one byte pending
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte dropped because storage was full
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to mid start bit; a high line there is a glitch
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; push the byte or flag frame_err

module uart_rx_mmio #(
   parameter int         CLK_HZ      = 50000000,
   parameter int         BAUD        = 9600,
   parameter logic [7:0] DATA_ADDR   = 8'hFD,
   parameter logic [7:0] STATUS_ADDR = 8'hFE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic [7:0] Address,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CPB_RAW = CLK_HZ / BAUD;
   localparam int CPB     = (CPB_RAW < 4) ? 4 : CPB_RAW;
   localparam int CNT_W   = $clog2(CPB);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t state, next_state;

   logic             rxd_m, rxd_s, rxd_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shreg;

   logic cnt_clr, cnt_inc, bit_sample, push, ferr_set;
   logic pop, stat_rd, full, push_ok, ovr_set;
   logic [7:0] head;

   // Synchronizer plus one extra stage for falling-edge detection. All
   // three reset high so a released reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m    <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_m    <= rxd;
         rxd_s    <= rxd_m;
         rxd_prev <= rxd_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (rxd_prev && !rxd_s) next_state = START;
         START: if (cnt == CNT_HALF)    next_state = rxd_s ? IDLE : DATA;
         DATA:  if (cnt == CNT_LAST && idx == 3'd7) next_state = STOP;
         STOP:  if (cnt == CNT_LAST)    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      bit_sample = 1'b0;
      push       = 1'b0;
      ferr_set   = 1'b0;
      case (state)
         IDLE: cnt_clr = 1'b1;
         START: begin
            if (cnt == CNT_HALF) cnt_clr = 1'b1;
            else                 cnt_inc = 1'b1;
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_clr    = 1'b1;
               bit_sample = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_clr = 1'b1;
               if (rxd_s) push     = 1'b1;
               else       ferr_set = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= 3'd0;
         shreg <= 8'h00;
      end else begin
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CNT_W'(1);

         if (bit_sample) begin
            shreg[idx] <= rxd_s;
            idx        <= idx + 3'd1;
         end else if (state == IDLE) begin
            idx <= 3'd0;
         end
      end
   end

   assign pop     = rd_en && (Address == DATA_ADDR) && rx_valid;
   assign stat_rd = rd_en && (Address == STATUS_ADDR);
   // A pop frees a slot in the same cycle, so push-while-full is accepted.
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;

`ifdef UART_RX_FIFO_EN
   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;

   assign full     = (count == 3'd4);
   assign rx_valid = (count != 3'd0);
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         // When full, wr_ptr == rd_ptr: the write lands in the slot being popped.
         if (push_ok) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end
`else
   logic [7:0] hold;
   logic       hold_valid;

   assign full     = hold_valid;
   assign rx_valid = hold_valid;
   assign head     = hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold       <= 8'h00;
         hold_valid <= 1'b0;
      end else begin
         if (push_ok) hold <= shreg;
         hold_valid <= push_ok || (hold_valid && !pop);
      end
   end
`endif

   // Set wins over a same-cycle status-read clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_set || (frame_err && !stat_rd);
         overrun   <= ovr_set  || (overrun   && !stat_rd);
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (Address == DATA_ADDR)        rd_data = head;
      else if (Address == STATUS_ADDR) rd_data = {5'b0, overrun, frame_err, rx_valid};
   end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Testbench for uart_rx_mmio at CLK_HZ=16, BAUD=1 (16 clocks per bit).
// Stimulus tasks queue the expected read value whenever they present a
// read; the monitor pops and compares at the falling edge of that cycle.

module tb_uart_rx_mmio;

   localparam logic [7:0] DA = 8'hFD;
   localparam logic [7:0] SA = 8'hFE;
   localparam int BIT = 16;
`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] Address = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rx_valid, frame_err, overrun;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } exp_t;

   exp_t q[$];
   bit   chk = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   uart_rx_mmio #(
      .CLK_HZ(16), .BAUD(1), .DATA_ADDR(DA), .STATUS_ADDR(SA)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .Address(Address), .rd_en(rd_en),
      .rd_data(rd_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk) begin
         n_checks++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_read: rd_data=%02h with no expected value", rd_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rd_data === e.exp) n_pass++;
            else $display("FAIL %s: rd_data=%02h expected %02h", e.name, rd_data, e.exp);
         end
      end
   end

   task automatic rd(input logic [7:0] a, input bit strobe, input logic [7:0] exp,
                     input string nm);
      @(posedge clk); #1;
      Address = a;
      rd_en   = strobe;
      q.push_back('{nm, exp});
      chk = 1'b1;
      @(posedge clk); #1;
      rd_en   = 1'b0;
      chk     = 1'b0;
      Address = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk); #1 rxd = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rxd = b[i];
         repeat (BIT) @(posedge clk);
      end
      #1 rxd = stop;
      repeat (BIT) @(posedge clk);
      #1 rxd = 1'b1;
      idle(20);
   endtask

   // Start bit, bits 0..3, then half of bit 4; leaves the line driven.
   task automatic send_partial(input logic [7:0] b);
      @(posedge clk); #1 rxd = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         #1 rxd = b[i];
         repeat ((i == 4) ? BIT / 2 : BIT) @(posedge clk);
      end
   endtask

   initial begin
      idle(3);
      #1 rst = 1'b0;
      idle(2);

      rd(SA, 1'b0, 8'h00, "reset_status");
      rd(DA, 1'b0, 8'h00, "reset_data");
      rd(8'h10, 1'b0, 8'h00, "unmapped_addr");

      send_byte(8'hA5, 1'b1);
      rd(SA, 1'b0, 8'h01, "a5_status_valid");
      rd(8'h00, 1'b0, 8'h00, "a5_unmapped");
      rd(DA, 1'b0, 8'hA5, "a5_peek");
      rd(DA, 1'b1, 8'hA5, "a5_pop");
      rd(SA, 1'b0, 8'h00, "a5_after_pop");

      @(posedge clk); #1 rxd = 1'b0;
      idle(3); #1 rxd = 1'b1;
      idle(40);
      rd(SA, 1'b0, 8'h00, "glitch_status");

      send_byte(8'h3C, 1'b0);
      rd(SA, 1'b0, 8'h02, "ferr_peek");
      rd(SA, 1'b1, 8'h02, "ferr_clear_read");
      rd(SA, 1'b0, 8'h00, "ferr_cleared");

`ifdef UART_RX_FIFO_EN
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      rd(SA, 1'b1, 8'h05, "ovr_status");
      rd(SA, 1'b0, 8'h01, "ovr_cleared");
      for (int i = 1; i <= 4; i++) rd(DA, 1'b1, 8'(i), "ovr_fifo_pop");
      rd(SA, 1'b0, 8'h00, "ovr_drained");
`else
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rd(DA, 1'b0, 8'h11, "ovr_hold_kept");
      rd(SA, 1'b1, 8'h05, "ovr_status");
      rd(DA, 1'b1, 8'h11, "ovr_pop");
      rd(SA, 1'b0, 8'h00, "ovr_drained");
`endif

      // Fill storage, then pop on the exact cycle the next byte is pushed
      // (stop-sample edge is 156 clocks after the start-bit drive edge).
      for (int i = 0; i < DEPTH; i++) send_byte(8'h31 + 8'(i), 1'b1);
      fork
         send_byte(8'h3F, 1'b1);
         begin
            repeat (156) @(posedge clk);
            #1;
            Address = DA;
            rd_en   = 1'b1;
            q.push_back('{"pushpop_head", 8'h31});
            chk = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
            chk   = 1'b0;
            Address = 8'h00;
         end
      join
      rd(SA, 1'b0, 8'h01, "pushpop_no_overrun");
      for (int i = 1; i < DEPTH; i++) rd(DA, 1'b1, 8'h31 + 8'(i), "pushpop_next");
      rd(DA, 1'b1, 8'h3F, "pushpop_new");
      rd(SA, 1'b0, 8'h00, "pushpop_empty");

      send_byte(8'h3C, 1'b0);
      send_byte(8'hAA, 1'b1);
      rd(SA, 1'b0, 8'h03, "pre_reset_status");
      send_partial(8'h0F);
      @(posedge clk); #1;
      rst = 1'b1;
      rxd = 1'b1;
      idle(2); #1 rst = 1'b0;
      idle(40);
      rd(SA, 1'b0, 8'h00, "midframe_reset_status");
      send_byte(8'h7E, 1'b1);
      rd(SA, 1'b0, 8'h01, "post_reset_valid");
      rd(DA, 1'b1, 8'h7E, "post_reset_7e");
      rd(SA, 1'b0, 8'h00, "post_reset_empty");

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d expected reads left, required 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
